// File: rtl/pll_rst_pkg.sv
// Shared state encoding and default parameter values for the PLL reset sequencer.
package pll_rst_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_SETTLE    = 3'd1,
    ST_MEM_INIT  = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  localparam int unsigned DEF_SYNC_STAGES    = 2;
  localparam int unsigned DEF_LOCK_FILTER    = 16;
  localparam int unsigned DEF_SETTLE_CYCLES  = 1024;
  localparam int unsigned DEF_INIT_TIMEOUT   = 1048576;
  localparam int unsigned DEF_RETRY_MAX      = 3;
  localparam int unsigned DEF_LOSS_CNT_WIDTH = 8;

  // Width of a counter that must be able to hold the value 'limit' (never narrower than 1 bit).
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_cdc_sync.sv
// N-stage single-bit synchronizer with asynchronous active-low reset; output resets to 0.
module cdc_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PSRAM and CPU resets from PLL lock: filter lock, settle, wait for memory init,
// retry on timeout, fall into a sticky fault after too many retries.
module pll_reset_sequencer
  import pll_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int unsigned LOCK_FILTER    = DEF_LOCK_FILTER,
  parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int unsigned INIT_TIMEOUT   = DEF_INIT_TIMEOUT,
  parameter int unsigned RETRY_MAX      = DEF_RETRY_MAX,
  parameter int unsigned LOSS_CNT_WIDTH = DEF_LOSS_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pll_lock_i,
  input  logic                      mem_init_done_i,
  output logic                      mem_rst_n_o,
  output logic                      sys_rst_n_o,
  output logic                      ready_o,
  output logic                      fault_o,
  output logic [2:0]                state_o,
  output logic [LOSS_CNT_WIDTH-1:0] lock_loss_cnt_o
);

  localparam int unsigned FW = cnt_width(LOCK_FILTER);
  localparam int unsigned SW = cnt_width(SETTLE_CYCLES);
  localparam int unsigned TW = cnt_width(INIT_TIMEOUT);
  localparam int unsigned RW = cnt_width(RETRY_MAX);
  localparam int unsigned LW = LOSS_CNT_WIDTH;

  localparam logic [FW-1:0] FiltMax    = FW'(LOCK_FILTER);
  localparam logic [FW-1:0] FiltLast   = FW'(LOCK_FILTER - 1);
  localparam logic [SW-1:0] SettleLast = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TmoLast    = TW'(INIT_TIMEOUT - 1);
  localparam logic [RW-1:0] RetryMax   = RW'(RETRY_MAX);

  logic lock_s;

  cdc_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock_i),
    .q     (lock_s)
  );

  state_e        state_q, state_d;
  logic [FW-1:0] filt_q, filt_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [LW-1:0] loss_q, loss_d;
  logic          mem_rst_n_q, sys_rst_n_q, ready_q, fault_q;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    tmo_d    = tmo_q;
    retry_d  = retry_q;
    loss_d   = loss_q;
    // Filter saturates so it cannot wrap while lock stays high outside WAIT_LOCK.
    if (!lock_s) begin
      filt_d = '0;
    end else if (filt_q != FiltMax) begin
      filt_d = filt_q + FW'(1);
    end else begin
      filt_d = filt_q;
    end

    unique case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_s && (filt_q == FiltLast)) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
      end
      ST_SETTLE, ST_MEM_INIT, ST_RUN: begin
        // Lock loss outranks settle completion, init done and timeout.
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          retry_d = '0;
          filt_d  = '0;
          if (loss_q != '1) begin
            loss_d = loss_q + LW'(1);
          end
        end else if (state_q == ST_SETTLE) begin
          settle_d = settle_q + SW'(1);
          if (settle_q == SettleLast) begin
            state_d = ST_MEM_INIT;
            tmo_d   = '0;
          end
        end else if (state_q == ST_MEM_INIT) begin
          tmo_d = tmo_q + TW'(1);
          if (mem_init_done_i) begin
            state_d = ST_RUN;
          end else if (tmo_q == TmoLast) begin
            if (retry_q < RetryMax) begin
              retry_d  = retry_q + RW'(1);
              settle_d = '0;
              state_d  = ST_SETTLE;
            end else begin
              state_d = ST_FAULT;
            end
          end
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_WAIT_LOCK;
    endcase
  end

  // Reset outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT_LOCK;
      filt_q      <= '0;
      settle_q    <= '0;
      tmo_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      mem_rst_n_q <= 1'b0;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      filt_q      <= filt_d;
      settle_q    <= settle_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      mem_rst_n_q <= (state_d == ST_MEM_INIT) || (state_d == ST_RUN);
      sys_rst_n_q <= (state_d == ST_RUN);
      ready_q     <= (state_d == ST_RUN);
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign mem_rst_n_o     = mem_rst_n_q;
  assign sys_rst_n_o     = sys_rst_n_q;
  assign ready_o         = ready_q;
  assign fault_o         = fault_q;
  assign state_o         = state_q;
  assign lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: vector table, hand-written corner sequences and random
// stimulus, all compared against a cycle-level reference model kept here.
module tb_pll_reset_sequencer;

  localparam int SYNC    = 2;
  localparam int FILT    = 4;
  localparam int SETTLE  = 8;
  localparam int TIMEOUT = 32;
  localparam int RETRY   = 2;

  localparam int PH_WAIT = 0, PH_SETTLE = 1, PH_INIT = 2, PH_RUN = 3, PH_FAULT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       mem_init_done = 1'b0;
  logic       mem_rst_n, sys_rst_n, ready, fault;
  logic [2:0] state;
  logic [7:0] loss_cnt;
  logic [14:0] dut_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .SYNC_STAGES    (SYNC),
    .LOCK_FILTER    (FILT),
    .SETTLE_CYCLES  (SETTLE),
    .INIT_TIMEOUT   (TIMEOUT),
    .RETRY_MAX      (RETRY),
    .LOSS_CNT_WIDTH (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pll_lock_i      (pll_lock),
    .mem_init_done_i (mem_init_done),
    .mem_rst_n_o     (mem_rst_n),
    .sys_rst_n_o     (sys_rst_n),
    .ready_o         (ready),
    .fault_o         (fault),
    .state_o         (state),
    .lock_loss_cnt_o (loss_cnt)
  );

  assign dut_out = {mem_rst_n, sys_rst_n, ready, fault, state, loss_cnt};

  function automatic logic [14:0] outs(input logic m, input logic s, input logic r,
                                       input logic f, input logic [2:0] st,
                                       input logic [7:0] c);
    return {m, s, r, f, st, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: raw lock history, run length of synced-high samples, phase + time in phase.
  int m_hist[SYNC];
  int m_run, m_phase, m_elapsed, m_retry, m_loss;

  function automatic void model_reset();
    for (int i = 0; i < SYNC; i++) m_hist[i] = 0;
    m_run = 0; m_phase = PH_WAIT; m_elapsed = 0; m_retry = 0; m_loss = 0;
  endfunction

  function automatic void model_step(input logic lock, input logic done);
    int ls;
    ls = m_hist[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = int'(lock);
    m_run = (ls != 0) ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
    if (m_phase == PH_WAIT) begin
      if (m_run >= FILT) begin m_phase = PH_SETTLE; m_elapsed = 0; end
    end else if (m_phase != PH_FAULT && ls == 0) begin
      m_phase = PH_WAIT; m_retry = 0;
      m_loss = (m_loss < 255) ? m_loss + 1 : 255;
    end else if (m_phase == PH_SETTLE) begin
      m_elapsed++;
      if (m_elapsed == SETTLE) begin m_phase = PH_INIT; m_elapsed = 0; end
    end else if (m_phase == PH_INIT) begin
      if (done) m_phase = PH_RUN;
      else begin
        m_elapsed++;
        if (m_elapsed == TIMEOUT) begin
          if (m_retry < RETRY) begin m_retry++; m_phase = PH_SETTLE; m_elapsed = 0; end
          else m_phase = PH_FAULT;
        end
      end
    end
  endfunction

  function automatic logic [14:0] model_out();
    return outs(m_phase == PH_INIT || m_phase == PH_RUN, m_phase == PH_RUN,
                m_phase == PH_RUN, m_phase == PH_FAULT, 3'(m_phase), 8'(m_loss));
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(pll_lock, mem_init_done);
    #1;
    check("model", 32'(dut_out), 32'(model_out()));
  endtask

  // Assert rst_n mid-cycle, confirm outputs clear before any clock edge, then release.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0; pll_lock = 1'b0; mem_init_done = 1'b0;
    #1;
    model_reset();
    check("async_reset", 32'(dut_out), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic wait_sig(input int which, input logic val, input int bound, output int n);
    n = 0;
    while (n < bound) begin
      tick();
      n++;
      if (((which == 0) ? mem_rst_n : fault) === val) break;
    end
  endtask

  typedef struct {
    logic        lock;
    logic        done;
    int          cycles;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    int dprob, lrate;

    model_reset();
    vecs[0] = '{1'b1, 1'b0, 5, outs(0, 0, 0, 0, 3'd0, 8'd0)};
    vecs[1] = '{1'b1, 1'b0, 1, outs(0, 0, 0, 0, 3'd1, 8'd0)};
    vecs[2] = '{1'b1, 1'b0, 7, outs(0, 0, 0, 0, 3'd1, 8'd0)};
    vecs[3] = '{1'b1, 1'b0, 1, outs(1, 0, 0, 0, 3'd2, 8'd0)};
    vecs[4] = '{1'b1, 1'b0, 4, outs(1, 0, 0, 0, 3'd2, 8'd0)};
    vecs[5] = '{1'b1, 1'b1, 1, outs(1, 1, 1, 0, 3'd3, 8'd0)};
    vecs[6] = '{1'b1, 1'b0, 3, outs(1, 1, 1, 0, 3'd3, 8'd0)};

    // Normal bring-up through the vector table.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      pll_lock = vecs[i].lock;
      mem_init_done = vecs[i].done;
      repeat (vecs[i].cycles) tick();
      check($sformatf("vec%0d", i), 32'(dut_out), 32'(vecs[i].exp));
    end

    // One-cycle lock drop in RUN.
    pll_lock = 1'b0; tick();
    pll_lock = 1'b1; tick(); tick();
    check("loss_in_run", 32'(dut_out), 32'(outs(0, 0, 0, 0, 3'd0, 8'd1)));
    mem_init_done = 1'b1;
    repeat (20) tick();
    check("rerun_after_loss", 32'(dut_out), 32'(outs(1, 1, 1, 0, 3'd3, 8'd1)));

    // Lock glitch: 3 high, 1 low, then high.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      pll_lock = (i != 3);
      tick();
      check("glitch_hold", {29'd0, mem_rst_n, sys_rst_n, state == 3'd0}, 32'd1);
    end
    tick();
    check("glitch_settle", 32'(state), 32'd1);

    // Init never completes: two retries then fault.
    do_reset();
    pll_lock = 1'b1;
    wait_sig(0, 1'b1, 40, n); check("to_mem_up0", n, 14);
    wait_sig(0, 1'b0, 60, n); check("to_timeout0", n, 32);
    wait_sig(0, 1'b1, 20, n); check("to_retry_low0", n, 8);
    wait_sig(0, 1'b0, 60, n); check("to_timeout1", n, 32);
    wait_sig(0, 1'b1, 20, n); check("to_retry_low1", n, 8);
    wait_sig(1, 1'b1, 60, n); check("to_fault", n, 32);
    check("fault_out", 32'(dut_out), 32'(outs(0, 0, 0, 1, 3'd4, 8'd0)));
    mem_init_done = 1'b1;
    for (int i = 0; i < 40; i++) begin
      pll_lock = i[2];
      tick();
    end
    check("fault_sticky", 32'(dut_out), 32'(outs(0, 0, 0, 1, 3'd4, 8'd0)));

    // Lock loss and done in the same MEM_INIT cycle, then loss counter saturation.
    do_reset();
    pll_lock = 1'b1;
    repeat (14) tick();
    check("reach_init", 32'(state), 32'd2);
    pll_lock = 1'b0; tick(); tick();
    mem_init_done = 1'b1; tick();
    check("loss_beats_done", 32'(dut_out), 32'(outs(0, 0, 0, 0, 3'd0, 8'd1)));
    mem_init_done = 1'b0;
    for (int e = 0; e < 300; e++) begin
      pll_lock = 1'b1; repeat (6) tick();
      pll_lock = 1'b0; repeat (3) tick();
    end
    check("loss_saturate", 32'(loss_cnt), 32'd255);

    // Reset in MEM_INIT, full restart, then done arriving on the timeout cycle.
    do_reset();
    pll_lock = 1'b1;
    repeat (16) tick();
    check("pre_reset_init", 32'(state), 32'd2);
    do_reset();
    pll_lock = 1'b1;
    wait_sig(0, 1'b1, 40, n); check("restart_mem_up", n, 14);
    repeat (31) tick();
    check("init_before_timeout", 32'(state), 32'd2);
    mem_init_done = 1'b1; tick();
    check("done_beats_timeout", 32'(dut_out), 32'(outs(1, 1, 1, 0, 3'd3, 8'd0)));

    // Random epochs against the model.
    for (int ep = 0; ep < 12; ep++) begin
      if (m_phase == PH_FAULT || $urandom_range(0, 2) == 0) do_reset();
      case ($urandom_range(0, 2))
        0:       dprob = 0;
        1:       dprob = 10;
        default: dprob = 50;
      endcase
      lrate = ($urandom_range(0, 1) == 0) ? 20 : 300;
      for (int c = 0; c < 250; c++) begin
        pll_lock = ($urandom_range(0, lrate - 1) != 0);
        mem_init_done = ($urandom_range(0, 99) < dprob);
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
